// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;
   localparam int ADDR_W_DEF = 5;
   localparam int BEAT_W     = 6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DONE  = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch address register: load has priority over increment, otherwise hold.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              inc,
   output logic [ADDR_W-1:0] addr
);

   always_ff @(posedge clk) begin
      if (rst)       addr <= '0;
      else if (load) addr <= load_addr;
      else if (inc)  addr <= addr + ADDR_W'(1);
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Issues a run of instruction addresses from START_ADDR to a latched last
// address, honouring downstream backpressure and redirect (jump) requests.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int START_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] last_addr,
   input  logic              inst_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [ADDR_W-1:0] inst_addr,
   output logic              inst_valid,
   output logic              reg_write,
   output logic              busy,
   output logic              done,
   output logic [BEAT_W-1:0] beat_count
);

   fetch_state_t      state, state_nxt;
   logic [ADDR_W-1:0] last_q, last_nxt;
   logic [ADDR_W-1:0] pc_load_addr;
   logic              pc_load, pc_inc;
   logic              valid_nxt, done_nxt;
   logic [BEAT_W-1:0] cnt_nxt;
   logic              start_ok, beat, at_last;

   // A redirect squashes the beat presented in the same cycle.
   assign start_ok = start && (state != S_FETCH);
   assign beat     = inst_valid && inst_ready && !redirect_valid;
   assign at_last  = (inst_addr == last_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         last_q     <= '0;
         inst_valid <= 1'b0;
         reg_write  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         beat_count <= '0;
      end else begin
         state      <= state_nxt;
         last_q     <= last_nxt;
         inst_valid <= valid_nxt;
         reg_write  <= valid_nxt;
         busy       <= (state_nxt == S_FETCH);
         done       <= done_nxt;
         beat_count <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_FETCH;
         S_FETCH:        if (beat && at_last) state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      valid_nxt    = inst_valid;
      done_nxt     = done;
      cnt_nxt      = beat_count;
      last_nxt     = last_q;
      pc_load      = 1'b0;
      pc_inc       = 1'b0;
      pc_load_addr = ADDR_W'(START_ADDR);
      if (start_ok) begin
         valid_nxt = 1'b1;
         done_nxt  = 1'b0;
         cnt_nxt   = '0;
         last_nxt  = last_addr;
         pc_load   = 1'b1;
      end else if (state == S_FETCH) begin
         if (redirect_valid) begin
            pc_load      = 1'b1;
            pc_load_addr = redirect_addr;
            valid_nxt    = 1'b1;
         end else if (beat) begin
            cnt_nxt = (beat_count == '1) ? beat_count : beat_count + BEAT_W'(1);
            if (at_last) begin
               valid_nxt = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               pc_inc = 1'b1;
            end
         end
      end
   end

   fetch_pc_reg #(.ADDR_W(ADDR_W)) u_pc (
      .clk       (clk),
      .rst       (rst),
      .load      (pc_load),
      .load_addr (pc_load_addr),
      .inc       (pc_inc),
      .addr      (inst_addr)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: two builds (START_ADDR 0 and 30) share stimulus.
module tb_fetch_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] last_addr;
   logic       inst_ready;
   logic       redirect_valid;
   logic [4:0] redirect_addr;

   logic [4:0] o_addr [2];
   logic       o_v    [2];
   logic       o_rw   [2];
   logic       o_busy [2];
   logic       o_done [2];
   logic [5:0] o_cnt  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.ADDR_W(5), .START_ADDR(0)) d0 (
      .clk(clk), .rst(rst), .start(start), .last_addr(last_addr),
      .inst_ready(inst_ready), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .inst_addr(o_addr[0]), .inst_valid(o_v[0]), .reg_write(o_rw[0]),
      .busy(o_busy[0]), .done(o_done[0]), .beat_count(o_cnt[0]));

   fetch_sequencer #(.ADDR_W(5), .START_ADDR(30)) d1 (
      .clk(clk), .rst(rst), .start(start), .last_addr(last_addr),
      .inst_ready(inst_ready), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .inst_addr(o_addr[1]), .inst_valid(o_v[1]), .reg_write(o_rw[1]),
      .busy(o_busy[1]), .done(o_done[1]), .beat_count(o_cnt[1]));

   // Reference model: each run is the list of addresses still to be accepted.
   typedef struct {
      int addr;
      int v;
      int done;
      int cnt;
   } snap_t;

   int    bq [2][$];
   snap_t sq [2][$];
   int    act [2], maddr [2], mlast [2], mdone [2], mcnt [2];

   function automatic int sa(int i);
      return (i == 0) ? 0 : 30;
   endfunction

   function automatic void load_seq(int i, int from, int lst);
      int a;
      a = from;
      bq[i].delete();
      for (int k = 0; k < 32; k++) begin
         bq[i].push_back(a);
         if (a == lst) break;
         a = (a + 1) % 32;
      end
   endfunction

   initial begin
      for (int i = 0; i < 2; i++) begin
         act[i] = 0; maddr[i] = 0; mlast[i] = 0; mdone[i] = 0; mcnt[i] = 0;
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         snap_t s;
         if (rst) begin
            act[i] = 0; mdone[i] = 0; mcnt[i] = 0; maddr[i] = 0; mlast[i] = 0;
            bq[i].delete();
         end else if (!act[i] && start) begin
            act[i] = 1; mdone[i] = 0; mcnt[i] = 0;
            mlast[i] = int'(last_addr);
            load_seq(i, sa(i), mlast[i]);
            maddr[i] = bq[i][0];
         end else if (act[i]) begin
            if (redirect_valid) begin
               load_seq(i, int'(redirect_addr), mlast[i]);
               maddr[i] = bq[i][0];
            end else if (inst_ready) begin
               if (mcnt[i] < 63) mcnt[i] = mcnt[i] + 1;
               void'(bq[i].pop_front());
               if (bq[i].size() == 0) begin
                  act[i] = 0; mdone[i] = 1;
               end else begin
                  maddr[i] = bq[i][0];
               end
            end
         end
         s.addr = maddr[i]; s.v = act[i]; s.done = mdone[i]; s.cnt = mcnt[i];
         sq[i].push_back(s);
      end
   end

   task automatic chk(string nm, int i, logic [31:0] got, int exp);
      checks++;
      if (got !== 32'(exp)) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, i, $time, got, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         snap_t s;
         if (sq[i].size() > 0) begin
            s = sq[i].pop_front();
            chk("inst_addr",  i, 32'(o_addr[i]), s.addr);
            chk("inst_valid", i, 32'(o_v[i]),    s.v);
            chk("reg_write",  i, 32'(o_rw[i]),   s.v);
            chk("busy",       i, 32'(o_busy[i]), s.v);
            chk("done",       i, 32'(o_done[i]), s.done);
            chk("beat_count", i, 32'(o_cnt[i]),  s.cnt);
         end
      end
   end

   task automatic wait_idle(int lim, string nm);
      int n;
      n = 0;
      while ((act[0] != 0 || act[1] != 0) && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (act[0] != 0 || act[1] != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout %s: still active after %0d cycles, expected done", nm, lim);
      end
   endtask

   task automatic pulse_start(int lst);
      @(negedge clk);
      start = 1'b1;
      last_addr = 5'(lst);
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hold, n;
      bit did;
      rst = 1'b1; start = 1'b0; last_addr = '0; inst_ready = 1'b1;
      redirect_valid = 1'b0; redirect_addr = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // straight run to 13 with ready high
      pulse_start(13);
      wait_idle(60, "run13");
      repeat (2) @(negedge clk);

      // backpressure at address 2
      pulse_start(5);
      hold = 0; n = 0;
      while (act[0] != 0 && n < 60) begin
         if (maddr[0] == 2 && hold < 2) begin
            inst_ready = 1'b0; hold++;
         end else begin
            inst_ready = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      inst_ready = 1'b1;
      wait_idle(60, "backpressure");

      // redirect 3 -> 9
      pulse_start(10);
      did = 0; n = 0;
      while (act[0] != 0 && n < 60) begin
         redirect_valid = (maddr[0] == 3 && !did);
         redirect_addr  = 5'd9;
         if (redirect_valid) did = 1;
         @(negedge clk);
         n++;
      end
      redirect_valid = 1'b0;
      wait_idle(60, "redirect");

      // reset mid-run at address 7, colliding with start and redirect
      pulse_start(20);
      n = 0;
      while (maddr[0] != 7 && n < 60) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1; start = 1'b1; redirect_valid = 1'b1; redirect_addr = 5'd4;
      @(negedge clk);
      rst = 1'b0; start = 1'b0; redirect_valid = 1'b0;
      repeat (2) @(negedge clk);
      pulse_start(3);
      wait_idle(60, "after_reset");

      // start ignored in FETCH, restarts from DONE
      pulse_start(8);
      repeat (2) @(negedge clk);
      start = 1'b1; last_addr = 5'd1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(60, "start_in_fetch");
      repeat (2) @(negedge clk);
      pulse_start(2);
      wait_idle(60, "restart_from_done");

      // wrap run for the START_ADDR=30 build, then single-beat for START==last
      pulse_start(1);
      wait_idle(60, "wrap");
      pulse_start(0);
      wait_idle(60, "single_beat");

      // random traffic
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         rst            = ($urandom_range(0, 99) < 2);
         start          = ($urandom_range(0, 99) < 8);
         last_addr      = 5'($urandom_range(0, 31));
         inst_ready     = ($urandom_range(0, 99) < 70);
         redirect_valid = ($urandom_range(0, 99) < 10);
         redirect_addr  = 5'($urandom_range(0, 31));
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
      wait_idle(80, "drain");
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
